// File: rtl/product_accum_pkg.sv
// Shared types and constants for product_accum: FSM states, product width, default sizing.
// Pure declarations; no latency or backpressure of its own.
package product_accum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam int PRODUCT_W     = 32;
    localparam int DEFAULT_COUNT = 8;
    localparam int DEFAULT_ACC_W = 40;

endpackage

// File: rtl/accum_add.sv
// Combinational accumulate adder with carry-out; saturates to all-ones when PRODUCT_ACCUM_SAT_EN is defined.
// Zero latency, no flow control.
module accum_add
    import product_accum_pkg::*;
#(
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic [ACC_W-1:0]     acc,
    input  logic [PRODUCT_W-1:0] in_product,
    output logic [ACC_W-1:0]     sum,
    output logic                 carry
);

    logic [ACC_W:0] w_full;

    assign w_full = {1'b0, acc} + {{(ACC_W + 1 - PRODUCT_W){1'b0}}, in_product};
    assign carry  = w_full[ACC_W];

`ifdef PRODUCT_ACCUM_SAT_EN
    // Once pinned at all-ones, any non-zero addend carries again, so the sum stays pinned.
    assign sum = carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
    assign sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accum.sv
// Sums COUNT products per batch and holds the result until out_ready; result valid one cycle after the last beat.
// in_ready is low while a result is held; optional saturation via PRODUCT_ACCUM_SAT_EN.
module product_accum
    import product_accum_pkg::*;
#(
    parameter int COUNT = DEFAULT_COUNT,
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PRODUCT_W-1:0] in_product,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 clear,
    output logic [ACC_W-1:0]     out_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow
);

    localparam logic [7:0] CNT_LAST = 8'(COUNT);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [7:0]         r_cnt;
    logic               r_ovf;

    logic [ACC_W-1:0]   w_sum;
    logic               w_carry;
    logic               w_accept;
    logic [7:0]         w_cnt_nxt;

    accum_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .acc        (r_acc),
        .in_product (in_product),
        .sum        (w_sum),
        .carry      (w_carry)
    );

    assign in_ready  = (r_state != HOLD);
    assign out_valid = (r_state == HOLD);
    assign out_sum   = r_acc;
    assign overflow  = r_ovf;
    assign w_accept  = in_valid && in_ready;
    assign w_cnt_nxt = r_cnt + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (clear) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                // IDLE keeps acc and cnt at zero, so it shares the ACCUM update path.
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_sum;
                        r_cnt   <= w_cnt_nxt;
                        r_ovf   <= r_ovf | w_carry;
                        r_state <= (w_cnt_nxt == CNT_LAST) ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_product_accum.sv
// Scoreboard bench for product_accum: three instances (COUNT=4/ACC_W=40, COUNT=4/ACC_W=33, COUNT=1).
module tb_product_accum;

    typedef struct packed {
        logic [63:0] sum;
        logic        ovf;
    } exp_t;

`ifdef PRODUCT_ACCUM_SAT_EN
    localparam logic [63:0] EXP_W33 = 64'h1_FFFF_FFFF;
`else
    localparam logic [63:0] EXP_W33 = 64'h1_FFFF_FFFC;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    // Instance A: COUNT=4, ACC_W=40
    logic        a_rst_n, a_in_valid, a_in_ready, a_clear, a_out_valid, a_out_ready, a_ovf;
    logic [31:0] a_prod;
    logic [39:0] a_sum;
    // Instance B: COUNT=4, ACC_W=33
    logic        b_rst_n, b_in_valid, b_in_ready, b_clear, b_out_valid, b_out_ready, b_ovf;
    logic [31:0] b_prod;
    logic [32:0] b_sum;
    // Instance C: COUNT=1, ACC_W=40
    logic        c_rst_n, c_in_valid, c_in_ready, c_clear, c_out_valid, c_out_ready, c_ovf;
    logic [31:0] c_prod;
    logic [39:0] c_sum;

    product_accum #(.COUNT(4), .ACC_W(40)) u_a (
        .clk(clk), .reset(a_rst_n), .in_product(a_prod), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .clear(a_clear), .out_sum(a_sum), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .overflow(a_ovf)
    );

    product_accum #(.COUNT(4), .ACC_W(33)) u_b (
        .clk(clk), .reset(b_rst_n), .in_product(b_prod), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .clear(b_clear), .out_sum(b_sum), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .overflow(b_ovf)
    );

    product_accum #(.COUNT(1), .ACC_W(40)) u_c (
        .clk(clk), .reset(c_rst_n), .in_product(c_prod), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .clear(c_clear), .out_sum(c_sum), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .overflow(c_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors pop one expected result per output handshake.
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_result", 64'(a_sum), 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_out_sum", 64'(a_sum), e.sum);
                chk("a_overflow", 64'(a_ovf), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_result", 64'(b_sum), 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_out_sum", 64'(b_sum), e.sum);
                chk("b_overflow", 64'(b_ovf), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (c_out_valid && c_out_ready) begin
            if (qc.size() == 0) begin
                chk("c_unexpected_result", 64'(c_sum), 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                exp_t e;
                e = qc.pop_front();
                chk("c_out_sum", 64'(c_sum), e.sum);
                chk("c_overflow", 64'(c_ovf), 64'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "timeout");
    end

    initial begin
        a_rst_n = 1'b0; a_in_valid = 1'b0; a_prod = '0; a_clear = 1'b0; a_out_ready = 1'b0;
        b_rst_n = 1'b0; b_in_valid = 1'b0; b_prod = '0; b_clear = 1'b0; b_out_ready = 1'b0;
        c_rst_n = 1'b0; c_in_valid = 1'b0; c_prod = '0; c_clear = 1'b0; c_out_ready = 1'b0;
        #2;
        chk("rst_out_sum", 64'(a_sum), 64'd0);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_overflow", 64'(a_ovf), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        step();
        step();
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        step();

        // Back-to-back 1..4 with out_ready high.
        a_out_ready = 1'b1;
        qa.push_back('{sum: 64'd10, ovf: 1'b0});
        for (int i = 1; i <= 4; i++) begin
            a_in_valid = 1'b1; a_prod = 32'(i);
            step();
        end
        a_in_valid = 1'b0;
        chk("valid_after_beat4", 64'(a_out_valid), 64'd1);
        chk("in_ready_in_hold", 64'(a_in_ready), 64'd0);
        step();
        chk("idle_after_take_valid", 64'(a_out_valid), 64'd0);
        chk("idle_after_take_sum", 64'(a_sum), 64'd0);

        // Held result under backpressure with in_valid kept high.
        a_out_ready = 1'b0;
        qa.push_back('{sum: 64'd10, ovf: 1'b0});
        for (int i = 1; i <= 4; i++) begin
            a_in_valid = 1'b1; a_prod = 32'(i);
            step();
        end
        a_prod = 32'd99;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_in_ready", 64'(a_in_ready), 64'd0);
            chk("hold_out_sum", 64'(a_sum), 64'd10);
            chk("hold_out_valid", 64'(a_out_valid), 64'd1);
        end
        a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        chk("release_out_valid", 64'(a_out_valid), 64'd0);
        chk("release_no_absorb", 64'(a_sum), 64'd0);

        // Mid-batch reset discards the partial sum.
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1; a_prod = 32'd7;
            step();
        end
        chk("partial_sum_21", 64'(a_sum), 64'd21);
        a_in_valid = 1'b0;
        a_rst_n = 1'b0;
        #1;
        chk("async_reset_sum", 64'(a_sum), 64'd0);
        chk("async_reset_in_ready", 64'(a_in_ready), 64'd1);
        step();
        step();
        a_rst_n = 1'b1;
        qa.push_back('{sum: 64'd20, ovf: 1'b0});
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_prod = 32'd5;
            step();
        end
        a_in_valid = 1'b0;
        step();

        // Clear together with a beat drops the beat.
        for (int i = 0; i < 2; i++) begin
            a_in_valid = 1'b1; a_prod = 32'd9;
            step();
        end
        a_clear = 1'b1;
        step();
        a_clear = 1'b0; a_in_valid = 1'b0;
        chk("clear_sum", 64'(a_sum), 64'd0);
        chk("clear_out_valid", 64'(a_out_valid), 64'd0);
        qa.push_back('{sum: 64'd12, ovf: 1'b0});
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1; a_prod = 32'd3;
            step();
        end
        a_in_valid = 1'b0;
        step();

        // ACC_W=33 overflow.
        b_out_ready = 1'b1;
        qb.push_back('{sum: EXP_W33, ovf: 1'b1});
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1; b_prod = 32'hFFFF_FFFF;
            step();
        end
        b_in_valid = 1'b0;
        chk("w33_overflow_flag", 64'(b_ovf), 64'd1);
        step();
        chk("w33_overflow_cleared", 64'(b_ovf), 64'd0);

        // COUNT=1 with both handshakes held high.
        c_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) qc.push_back('{sum: 64'(2 * i), ovf: 1'b0});
        for (int i = 0; i < 10; i++) begin
            c_in_valid = 1'b1; c_prod = 32'(i);
            chk("c1_in_ready_alt", 64'(c_in_ready), ((i % 2) == 0) ? 64'd1 : 64'd0);
            step();
        end
        c_in_valid = 1'b0;
        step();
        step();

        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);
        chk("qc_drained", 64'(qc.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/product_accum.md
PRODUCT_ACCUM -- requirements
Module: product_accum

Interface
- REQ-001 SHALL have parameter COUNT, default 8: products summed per batch, legal range 1..255.
- REQ-002 SHALL have parameter ACC_W, default 40: accumulator width, legal range 33..64.
- REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
- REQ-004 SHALL have port reset, input, 1: one clock; reset is asynchronous and active-low.
- REQ-005 SHALL have port in_product, input, 32: unsigned product from the upstream 16x16 multiplier.
- REQ-006 SHALL have port in_valid, input, 1: in_product is valid this cycle.
- REQ-007 SHALL have port in_ready, output, 1: the block accepts a product this cycle.
- REQ-008 SHALL have port clear, input, 1: synchronous batch abort.
- REQ-009 SHALL have port out_sum, output, ACC_W: batch sum.
- REQ-010 SHALL have port out_valid, output, 1: out_sum is valid.
- REQ-011 SHALL have port out_ready, input, 1: the consumer takes out_sum.
- REQ-012 SHALL have port overflow, output, 1: the current batch exceeded the ACC_W range.

Function
- REQ-013 SHALL accept a beat only when in_valid=1 and in_ready=1; there are no other accept conditions.
- REQ-014 SHALL implement states IDLE, ACCUM and HOLD.
- REQ-015 IDLE behaviour:
  - in_ready=1; acc=0, cnt=0.
  - On accept: acc=in_product, cnt=1.
  - Next state is ACCUM, or HOLD if COUNT=1.
- REQ-016 ACCUM behaviour:
  - in_ready=1.
  - On accept: acc=acc+in_product (zero-extended), cnt=cnt+1.
  - Go to HOLD on the beat where cnt reaches COUNT.
- REQ-017 HOLD behaviour:
  - in_ready=0, out_valid=1; out_sum and overflow are stable.
  - When out_ready=1: return to IDLE and drop out_valid next cycle; no beat is accepted in that cycle.
- REQ-018 out_valid SHALL rise exactly one cycle after the COUNT-th accepted beat.
- REQ-019 in_valid without in_ready SHALL leave acc, cnt and state unchanged.
- REQ-020 clear=1 in any state SHALL, next cycle, give: state IDLE, acc=0, cnt=0, overflow=0, out_valid=0.
  - clear overrides accept and out_ready in the same cycle.
- REQ-021 overflow SHALL set when an addition carries beyond ACC_W bits, stay set for the rest of the batch, and clear on leaving HOLD.
- REQ-022 out_sum SHALL equal acc in every state.

Reset
- REQ-023 While reset=0, the block SHALL immediately hold: state IDLE, acc=0, cnt=0, out_sum=0, out_valid=0, overflow=0, in_ready=1.
- REQ-024 Reset asserted mid-batch SHALL discard the partial sum; the first accepted beat after release starts a new batch.

Configuration
- REQ-025 With PRODUCT_ACCUM_SAT_EN defined, acc SHALL saturate at all-ones on overflow and stay there until the batch ends.
- REQ-026 Without PRODUCT_ACCUM_SAT_EN, acc SHALL wrap modulo 2^ACC_W; overflow is still reported.

Structure
- REQ-027 Shared package product_accum_pkg SHALL hold:
  - the state enumeration (IDLE, ACCUM, HOLD);
  - constant PRODUCT_W=32;
  - the default COUNT and ACC_W values.
- REQ-028 The adder/saturation datapath SHALL be sub-module accum_add (operands acc and in_product; outputs sum and carry); the FSM and counter stay in product_accum.

Verification
- REQ-029 COUNT=4, products 1,2,3,4 back-to-back, out_ready=1 -> out_sum=10, overflow=0, out_valid high one cycle after beat 4, then IDLE.
- REQ-030 Batch complete, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_sum held at 10, no beat absorbed; out_ready=1 -> IDLE next cycle.
- REQ-031 COUNT=4, three beats of 7, then reset=0 for 2 cycles -> out_sum=0 immediately; after release, four beats of 5 -> out_sum=20.
- REQ-032 COUNT=4, two beats of 9, clear=1 together with a third beat -> beat dropped, acc=0; next four beats of 3 -> out_sum=12.
- REQ-033 ACC_W=33, COUNT=4, four beats of 0xFFFFFFFF -> overflow=1:
  - with PRODUCT_ACCUM_SAT_EN, out_sum=0x1FFFFFFFF;
  - without it, out_sum=0x1FFFFFFFC.
- REQ-034 COUNT=1, in_valid and out_ready held high for 10 cycles with products 0..9 -> in_ready alternates 1/0; five results 0,2,4,6,8 appear, one every 2 cycles.
